// File: rtl/argo_queue_reader.sv
// Turns a 1-cycle-latency FIFO read port into a valid/ready stream.
// A 2-slot ordered buffer plus one in-flight read keeps the stream at full rate.
module argo_queue_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int CHAN_ID    = 7
) (
  input  logic                  clock,
  input  logic                  resetn,
  output logic                  q_rd_en,
  input  logic [DATA_WIDTH-1:0] q_rd_data,
  input  logic                  q_empty,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [31:0]           word_count
);

  // CHAN_ID only tags the instance for trace; it never alters behaviour.
  if (CHAN_ID < 0) begin : g_bad_chan_id
  end

  logic [1:0][DATA_WIDTH-1:0] slots;
  logic [1:0]                 buf_cnt;
  logic                       inflight;
  logic                       armed;
  logic                       pop;
  logic [2:0]                 occ;

  assign out_valid = (buf_cnt != 2'd0);
  assign out_data  = slots[0];
  assign pop       = out_valid && out_ready;
  assign occ       = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};

  // armed holds reads off until the first clock edge after reset release.
  assign q_rd_en = !q_empty && resetn && armed && (occ < 3'd2);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      slots      <= '0;
      buf_cnt    <= 2'd0;
      inflight   <= 1'b0;
      armed      <= 1'b0;
      word_count <= 32'd0;
    end else begin
      armed    <= 1'b1;
      inflight <= q_rd_en;
      if (pop) word_count <= word_count + 32'd1;
      case ({pop, inflight})
        2'b01: begin
          slots[buf_cnt[0]] <= q_rd_data;
          buf_cnt           <= buf_cnt + 2'd1;
        end
        2'b10: begin
          slots[0] <= slots[1];
          buf_cnt  <= buf_cnt - 2'd1;
        end
        2'b11: begin
          // Head leaves while a new word lands: count stays, order shifts.
          if (buf_cnt == 2'd2) begin
            slots[0] <= slots[1];
            slots[1] <= q_rd_data;
          end else begin
            slots[0] <= q_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_argo_queue_reader.sv
// Directed bench for argo_queue_reader: bench-side FIFO, queue-based model
// checked every cycle, plus literal expectations for each scenario.
module tb_argo_queue_reader;

  logic        clock = 1'b0;
  logic        resetn;
  logic        q_rd_en;
  logic [31:0] q_rd_data;
  logic        q_empty;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [31:0] word_count;

  argo_queue_reader #(.DATA_WIDTH(32), .CHAN_ID(7)) dut (
    .clock(clock), .resetn(resetn), .q_rd_en(q_rd_en), .q_rd_data(q_rd_data),
    .q_empty(q_empty), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .word_count(word_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] fifo[$];
  logic [31:0] mq[$];
  logic        m_infl;
  logic [31:0] m_infl_word;
  logic        m_armed;
  logic [31:0] m_cnt;
  logic        hold_prev;
  logic [31:0] prev_data;

  logic        rd_log[$];
  logic        vld_log[$];
  logic [31:0] got[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    logic exp_vld, pop, exp_rd, rd_s;
    int   occ;
    @(negedge clock);
    exp_vld = (mq.size() != 0);
    pop     = exp_vld && out_ready;
    occ     = mq.size() + int'(m_infl) - int'(pop);
    exp_rd  = resetn && !q_empty && m_armed && (occ < 2);
    check("q_rd_en", 32'(q_rd_en), 32'(exp_rd));
    check("out_valid", 32'(out_valid), 32'(exp_vld));
    check("word_count", word_count, m_cnt);
    if (exp_vld) check("out_data", out_data, mq[0]);
    if (hold_prev) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", out_data, prev_data);
    end
    hold_prev = resetn && out_valid && !out_ready;
    prev_data = out_data;
    rd_log.push_back(q_rd_en);
    vld_log.push_back(out_valid);
    if (out_valid && out_ready) got.push_back(out_data);
    rd_s = q_rd_en;
    @(posedge clock);
    #1;
    if (!resetn) begin
      mq.delete(); m_infl = 1'b0; m_armed = 1'b0; m_cnt = 32'd0;
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        m_cnt++;
      end
      if (m_infl) mq.push_back(m_infl_word);
      m_infl  = exp_rd;
      m_armed = 1'b1;
      check("occupancy_le_2", 32'(mq.size() + int'(m_infl) <= 2), 32'd1);
    end
    if (rd_s && resetn && fifo.size() > 0) begin
      q_rd_data   = fifo.pop_front();
      m_infl_word = q_rd_data;
    end
    q_empty = (fifo.size() == 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    mq.delete(); m_infl = 1'b0; m_armed = 1'b0; m_cnt = 32'd0;
    fifo.delete(); q_empty = 1'b1; hold_prev = 1'b0;
    #1;
    check("rst_q_rd_en", 32'(q_rd_en), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_word_count", word_count, 32'd0);
    run(2);
  endtask

  task automatic load(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) fifo.push_back(base + 32'(i));
    q_empty = (fifo.size() == 0);
  endtask

  task automatic release_reset();
    rd_log.delete(); vld_log.delete(); got.delete();
    resetn = 1'b1;
  endtask

  function automatic int first_rd();
    for (int i = 0; i < rd_log.size(); i++) if (rd_log[i]) return i;
    return -1;
  endfunction

  function automatic int count_rd();
    int c = 0;
    foreach (rd_log[i]) if (rd_log[i]) c++;
    return c;
  endfunction

  function automatic int longest_vld_run();
    int best = 0, cur = 0;
    foreach (vld_log[i]) begin
      cur = vld_log[i] ? cur + 1 : 0;
      if (cur > best) best = cur;
    end
    return best;
  endfunction

  task automatic check_got(input string name, input logic [31:0] base, input int n);
    check({name, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++) check({name, "_order"}, got[i], base + 32'(i));
  endtask

  initial begin
    int t0;
    bit reached;
    resetn = 1'b0; out_ready = 1'b1; q_rd_data = 32'd0;
    m_infl = 1'b0; m_armed = 1'b0; m_cnt = 32'd0; m_infl_word = 32'd0;
    hold_prev = 1'b0; prev_data = 32'd0;
    fifo = '{32'hA, 32'hB, 32'hC};
    q_empty = 1'b0;
    #1;
    // Reset with a non-empty FIFO, before any clock edge.
    check("rst0_q_rd_en", 32'(q_rd_en), 32'd0);
    check("rst0_out_valid", 32'(out_valid), 32'd0);
    check("rst0_out_data", out_data, 32'd0);
    check("rst0_word_count", word_count, 32'd0);
    run(2);

    // Stream A,B,C with ready high.
    release_reset();
    run(10);
    t0 = first_rd();
    check("stream_t0_found", 32'(t0 >= 1), 32'd1);
    if (t0 >= 1) begin
      check("stream_rd_t0", 32'(rd_log[t0]), 32'd1);
      check("stream_rd_t1", 32'(rd_log[t0+1]), 32'd1);
      check("stream_rd_t2", 32'(rd_log[t0+2]), 32'd1);
      check("stream_rd_t3", 32'(rd_log[t0+3]), 32'd0);
      check("stream_vld_t1", 32'(vld_log[t0+1]), 32'd0);
      check("stream_vld_t2", 32'(vld_log[t0+2]), 32'd1);
      check("stream_vld_t4", 32'(vld_log[t0+4]), 32'd1);
      check("stream_vld_t5", 32'(vld_log[t0+5]), 32'd0);
    end
    check_got("stream", 32'hA, 3);
    check("stream_word_count", word_count, 32'd3);

    // Backpressure: 5 words, consumer stalled.
    out_ready = 1'b0;
    do_reset();
    load(32'h100, 5);
    release_reset();
    run(8);
    check("bp_rd_pulses", 32'(count_rd()), 32'd2);
    check("bp_rd_now", 32'(q_rd_en), 32'd0);
    check("bp_head_valid", 32'(out_valid), 32'd1);
    check("bp_head_data", out_data, 32'h100);
    out_ready = 1'b1;
    run(10);
    check_got("bp", 32'h100, 5);
    check("bp_word_count", word_count, 32'd5);

    // Full rate: 8 words with no bubbles.
    do_reset();
    load(32'h300, 8);
    release_reset();
    run(14);
    check("full_rate_run", 32'(longest_vld_run()), 32'd8);
    check_got("full", 32'h300, 8);

    // Reset while one word is buffered and one is in flight.
    out_ready = 1'b0;
    do_reset();
    load(32'h400, 3);
    release_reset();
    reached = 1'b0;
    for (int i = 0; i < 10 && !reached; i++) begin
      cycle();
      reached = (mq.size() == 1) && m_infl;
    end
    check("midrst_state_reached", 32'(reached), 32'd1);
    do_reset();
    release_reset();
    run(6);
    check("midrst_no_valid", 32'(longest_vld_run()), 32'd0);
    check("midrst_word_count", word_count, 32'd0);

    // Alternating ready over 6 words.
    do_reset();
    load(32'h500, 6);
    out_ready = 1'b1;
    release_reset();
    for (int i = 0; i < 20; i++) begin
      cycle();
      out_ready = ~out_ready;
    end
    check_got("toggle", 32'h500, 6);
    check("toggle_word_count", word_count, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/argo_queue_reader.md
ARGO_QUEUE_READER -- requirements
Module: argo_queue_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the channel word width in bits.
REQ-002 The block SHALL have parameter CHAN_ID, default 7, a channel identifier for debug and trace only, with no functional effect.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port q_rd_en, output, 1 bit: read strobe to the upstream channel FIFO.
REQ-006 The block SHALL have port q_rd_data, input, DATA_WIDTH bits: FIFO read data, valid in the cycle after the q_rd_en cycle.
REQ-007 The block SHALL have port q_empty, input, 1 bit: FIFO empty flag.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data holds a channel word.
REQ-009 The block SHALL have port out_data, output, DATA_WIDTH bits: the head channel word.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the word this cycle.
REQ-011 The block SHALL have port word_count, output, 32 bits: the number of words delivered.

Function
REQ-012 The block SHALL convert the FIFO's 1-cycle-latency read port into a valid/ready stream using a 2-entry ordered buffer.
REQ-013 The block SHALL define pop as out_valid && out_ready, and a word SHALL transfer only on pop.
REQ-014 q_rd_en SHALL be combinational: !q_empty && resetn && (buf_cnt + inflight - pop) < 2.
REQ-015 The inflight register SHALL load the value of q_rd_en on every clock edge.
REQ-016 When inflight=1, q_rd_data SHALL be written to the buffer tail on that edge.
REQ-017 Capture and pop in the same cycle SHALL both take effect: buf_cnt unchanged, order preserved.
REQ-018 Invariant: buf_cnt + inflight <= 2 at all times; buffer overflow SHALL be impossible.
REQ-019 out_valid SHALL equal (buf_cnt != 0), driven from registers only, with no combinational path from q_rd_data.
REQ-020 out_data SHALL be the oldest buffered word; when out_valid=0 its value is don't-care.
REQ-021 out_data and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 Latency SHALL be 2 cycles: q_rd_en in cycle t gives out_valid in cycle t+2, given an empty buffer.
REQ-023 Throughput SHALL be 1 word per cycle in steady state when q_empty=0 and out_ready=1.
REQ-024 word_count SHALL increment by 1 on each pop and wrap from 2^32-1 to 0.
REQ-025 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-026 While resetn=0, asynchronously: buf_cnt=0, inflight=0, out_valid=0, out_data=0, word_count=0, q_rd_en=0.
REQ-027 Reset asserted mid-operation SHALL discard buffered and in-flight words, and no stale word SHALL appear after release.
REQ-028 The first q_rd_en after release SHALL occur no earlier than the first rising edge with resetn=1.

Verification
REQ-029 Reset: resetn=0 with q_empty=0 -> q_rd_en=0, out_valid=0, out_data=0, word_count=0 immediately, without waiting for a clock edge.
REQ-030 Stream: FIFO holds A,B,C, out_ready=1 -> q_rd_en high in cycles 0-2, out_valid high in cycles 2-4 carrying A,B,C, then word_count=3.
REQ-031 Backpressure: out_ready=0, FIFO holds 5 words -> exactly 2 q_rd_en pulses, then q_rd_en=0 and out_data=word0 held stable; out_ready=1 -> words 0-4 delivered in order with no loss or duplication.
REQ-032 Full rate: 8 words, out_ready=1 -> 8 consecutive out_valid cycles with no bubbles, and the buffer never exceeds 2 entries.
REQ-033 Mid-reset: resetn pulsed low while inflight=1 and buf_cnt=1 -> out_valid=0 at once; after release with q_empty=1, out_valid stays 0 and word_count=0.
REQ-034 Toggle ready: out_ready alternates 1,0 over a 6-word stream -> out_data is unchanged during each 0 cycle, all 6 words are delivered in order, and word_count=6.
